// File: rtl/load_unit.sv
// Load execution stage: one word-aligned memory read per load, byte/half/word
// extraction with sign or zero extension, and misaligned/illegal/timeout faults.
module load_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr_in,
   input  logic [4:0]      rd_idx_in,
   output logic            busy,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [31:0]     mem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            fault,
   output logic [1:0]      fault_cause
);

   // Handshake: mem_req rises on entry to WAIT and, together with mem_addr,
   // stays stable until the first cycle mem_ack is seen high; that cycle
   // transfers mem_rdata. mem_ack in any other state is ignored.

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t          state;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q;
   logic [4:0]      rd_q;
   logic [CW-1:0]   cnt;

   logic            illegal;
   logic            misaligned;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [XLEN-1:0] word_v;
   logic [XLEN-1:0] ext;

   assign busy = (state != IDLE);

   always_comb begin
      illegal = 1'b0;
      case (f3_q)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
         default:                                illegal = 1'b1;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (f3_q)
         3'b001, 3'b101: misaligned = addr_q[0];
         3'b010:         misaligned = (addr_q[1:0] != 2'b00);
         default:        misaligned = 1'b0;
      endcase
   end

   // Extraction works on the live read word so the result registers on the ack edge.
   always_comb begin
      byte_v       = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v       = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      word_v       = '0;
      word_v[31:0] = mem_rdata;
      case (f3_q)
         3'b000:  ext = {{(XLEN-8){byte_v[7]}}, byte_v};
         3'b001:  ext = {{(XLEN-16){half_v[15]}}, half_v};
         3'b100:  ext = {{(XLEN-8){1'b0}}, byte_v};
         3'b101:  ext = {{(XLEN-16){1'b0}}, half_v};
         default: ext = word_v;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state       <= IDLE;
         f3_q        <= '0;
         addr_q      <= '0;
         rd_q        <= '0;
         cnt         <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         wb_valid    <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
         case (state)
            IDLE: begin
               if (start) begin
                  f3_q   <= funct3;
                  addr_q <= addr_in;
                  rd_q   <= rd_idx_in;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               cnt <= '0;
               if (illegal) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'b10;
                  state       <= ERR;
               end else if (misaligned) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'b01;
                  state       <= ERR;
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= {addr_q[XLEN-1:2], 2'b00};
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // An ack on the final allowed cycle still completes the load.
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_rd    <= rd_q;
                  wb_data  <= ext;
                  state    <= DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  mem_req     <= 1'b0;
                  fault       <= 1'b1;
                  fault_cause <= 2'b11;
                  state       <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: latency, extraction, faults, timeout, reset abort
// and back-to-back loads against hand-computed expectations.
module tb_load_unit;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] addr_in;
   logic [4:0]  rd_idx_in;
   logic        busy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [1:0]  fault_cause;

   int total = 0;
   int bad   = 0;

   load_unit #(.XLEN(32), .TIMEOUT(15)) dut (
      .CLK(CLK), .reset(reset), .start(start), .funct3(funct3), .addr_in(addr_in),
      .rd_idx_in(rd_idx_in), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .fault(fault), .fault_cause(fault_cause)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Presents a start for one edge; afterwards the unit sits in CHECK.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
      start = 1'b1; funct3 = f3; addr_in = a; rd_idx_in = rd;
      tick();
      start = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (reset === 1'b1) begin
         total++;
         if (fault === 1'b1 && wb_valid === 1'b1) begin
            bad++; $display("FAIL excl fault=%b wb_valid=%b exp not both 1", fault, wb_valid);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wbv got=%b exp=0", wb_valid); end
      total++; if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb got=%h/%0d exp=0/0", wb_data, wb_rd); end
      total++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin bad++; $display("FAIL rst_fault got=%b/%b exp=0/00", fault, fault_cause); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_lb();
      issue(3'b000, 32'h1003, 5'd7);
      total++; if (busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL lb_c1 busy=%b req=%b exp 1/0", busy, mem_req); end
      tick();
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lb_req got=%b exp=1", mem_req); end
      total++; if (mem_addr !== 32'h1000) begin bad++; $display("FAIL lb_addr got=%h exp=00001000", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h80FF1122;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lb_wbv got=%b exp=1", wb_valid); end
      total++; if (wb_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", wb_data); end
      total++; if (wb_rd !== 5'd7) begin bad++; $display("FAIL lb_rd got=%0d exp=7", wb_rd); end
      total++; if (mem_req !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL lb_done req=%b fault=%b exp 0/0", mem_req, fault); end
      mem_ack = 1'b1; mem_rdata = 32'h0;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL lb_idle wbv=%b busy=%b exp 0/0", wb_valid, busy); end
      total++; if (wb_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_hold got=%h exp=ffffff80", wb_data); end
      tick();
      total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL lb_stray_ack busy=%b req=%b exp 0/0", busy, mem_req); end
   endtask

   task automatic test_lhu();
      int req_cycles = 0;
      issue(3'b101, 32'h2002, 5'd9);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (mem_req === 1'b1) req_cycles++;
         tick();
      end
      mem_ack = 1'b1; mem_rdata = 32'hBEEF0000;
      if (mem_req === 1'b1) req_cycles++;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lhu_wbv got=%b exp=1", wb_valid); end
      total++; if (wb_data !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_data got=%h exp=0000beef", wb_data); end
      total++; if (wb_rd !== 5'd9) begin bad++; $display("FAIL lhu_rd got=%0d exp=9", wb_rd); end
      for (int i = 0; i < 3; i++) begin
         if (mem_req === 1'b1) req_cycles++;
         tick();
      end
      total++; if (req_cycles != 5) begin bad++; $display("FAIL lhu_req_len got=%0d exp=5", req_cycles); end
   endtask

   task automatic test_faults();
      logic [2:0]  f3s   [4];
      logic [31:0] addrs [4];
      logic [1:0]  causes[4];
      f3s[0] = 3'b010; addrs[0] = 32'h6; causes[0] = 2'b01;
      f3s[1] = 3'b001; addrs[1] = 32'h5; causes[1] = 2'b01;
      f3s[2] = 3'b111; addrs[2] = 32'h3; causes[2] = 2'b10;
      f3s[3] = 3'b110; addrs[3] = 32'h8; causes[3] = 2'b10;
      for (int v = 0; v < 4; v++) begin
         issue(f3s[v], addrs[v], 5'd3);
         tick();
         total++; if (fault !== 1'b1 || fault_cause !== causes[v]) begin bad++; $display("FAIL flt%0d got=%b/%b exp=1/%b", v, fault, fault_cause, causes[v]); end
         total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL flt%0d_req req=%b wbv=%b exp 0/0", v, mem_req, wb_valid); end
         tick();
         total++; if (fault !== 1'b0 || fault_cause !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL flt%0d_clr got=%b/%b/%b exp=0/00/0", v, fault, fault_cause, busy); end
      end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      issue(3'b010, 32'h10, 5'd3);
      tick();
      for (int i = 0; i < 15; i++) begin
         if (mem_req === 1'b1) req_cycles++;
         tick();
      end
      total++; if (req_cycles != 15) begin bad++; $display("FAIL to_req_len got=%0d exp=15", req_cycles); end
      total++; if (fault !== 1'b1 || fault_cause !== 2'b11) begin bad++; $display("FAIL to_fault got=%b/%b exp=1/11", fault, fault_cause); end
      total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_req req=%b wbv=%b exp 0/0", mem_req, wb_valid); end
      tick();
      issue(3'b010, 32'h10, 5'd12);
      tick();
      for (int i = 0; i < 14; i++) tick();
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL to15_req got=%b exp=1", mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL to15_win wbv=%b fault=%b exp 1/0", wb_valid, fault); end
      total++; if (wb_data !== 32'h12345678 || wb_rd !== 5'd12) begin bad++; $display("FAIL to15_data got=%h/%0d exp=12345678/12", wb_data, wb_rd); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(3'b010, 32'h20, 5'd4);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      total++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rm_clr busy=%b req=%b addr=%h exp 0/0/0", busy, mem_req, mem_addr); end
      total++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || fault !== 1'b0) begin bad++; $display("FAIL rm_wb data=%h rd=%0d fault=%b exp 0/0/0", wb_data, wb_rd, fault); end
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_late_ack wbv=%b busy=%b exp 0/0", wb_valid, busy); end
      issue(3'b010, 32'h24, 5'd6);
      tick();
      total++; if (mem_addr !== 32'h24) begin bad++; $display("FAIL rm_addr got=%h exp=00000024", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_rd !== 5'd6) begin bad++; $display("FAIL rm_lw got=%b/%h/%0d exp=1/cafef00d/6", wb_valid, wb_data, wb_rd); end
      tick();
   endtask

   task automatic test_start_while_busy();
      issue(3'b100, 32'h0, 5'd10);
      start = 1'b1; funct3 = 3'b000; addr_in = 32'h3; rd_idx_in = 5'd20;
      tick();
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL swb_addr got=%h exp=0", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h0000AB80;
      tick();
      mem_ack = 1'b0; start = 1'b0;
      total++; if (wb_rd !== 5'd10) begin bad++; $display("FAIL swb_rd got=%0d exp=10", wb_rd); end
      total++; if (wb_data !== 32'h00000080) begin bad++; $display("FAIL swb_data got=%h exp=00000080", wb_data); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL swb_idle got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      issue(3'b100, 32'h0, 5'd1);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0000AB80;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_data !== 32'h00000080 || wb_rd !== 5'd1) begin bad++; $display("FAIL b2b_1 got=%b/%h/%0d exp=1/00000080/1", wb_valid, wb_data, wb_rd); end
      tick();
      issue(3'b100, 32'h1, 5'd2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0000AB80;
      tick();
      mem_ack = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_data !== 32'h000000AB || wb_rd !== 5'd2) begin bad++; $display("FAIL b2b_2 got=%b/%h/%0d exp=1/000000ab/2", wb_valid, wb_data, wb_rd); end
      tick();
   endtask

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      reset = 1'b0; start = 1'b0; funct3 = 3'b000; addr_in = '0; rd_idx_in = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_lb();
      test_lhu();
      test_faults();
      test_timeout();
      test_reset_mid();
      test_start_while_busy();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
